// File: rtl/spi_reg_controller.sv
// spi_reg_controller: bridges byte frames from an SPI slave to a register bus.
// Parameters: ADDR_WIDTH register address width, MAX_BURST data bytes accepted per frame.
// Inputs : i_clk, i_rst (async, active high), i_spi_ready (byte strobe), i_spi_data_rx (byte),
//          i_spi_busy (frame active), i_reg_rdata (read data, one cycle after o_reg_rd).
// Outputs: o_spi_data_tx (next byte to shift out), o_reg_addr, o_reg_wdata, o_reg_wr, o_reg_rd,
//          o_burst_err (sticky overflow flag), o_frame_active.
module spi_reg_controller #(
    parameter int ADDR_WIDTH = 7,
    parameter int MAX_BURST  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_spi_ready,
    input  logic [7:0]            i_spi_data_rx,
    input  logic                  i_spi_busy,
    output logic [7:0]            o_spi_data_tx,
    output logic [ADDR_WIDTH-1:0] o_reg_addr,
    output logic [7:0]            o_reg_wdata,
    output logic                  o_reg_wr,
    output logic                  o_reg_rd,
    input  logic [7:0]            i_reg_rdata,
    output logic                  o_burst_err,
    output logic                  o_frame_active
);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [2:0] {IDLE, ARMED, WAIT_CMD, WR_DATA, RD_DATA} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   count;
    logic            capture;
    logic            in_burst, cmd_byte, wr_byte, rd_byte, over_byte, frame_start;

    assign in_burst    = count < CW'(MAX_BURST);
    assign cmd_byte    = state == WAIT_CMD && i_spi_ready;
    assign wr_byte     = state == WR_DATA && i_spi_ready && in_burst;
    assign rd_byte     = state == RD_DATA && i_spi_ready && in_burst;
    assign over_byte   = (state == WR_DATA || state == RD_DATA) && i_spi_ready && !in_burst;
    // ARMED is only reached with busy low, so busy high here is the frame's rising edge
    assign frame_start = state == ARMED && i_spi_busy;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     state_next = i_spi_busy ? IDLE : ARMED;
            ARMED:    state_next = i_spi_busy ? WAIT_CMD : ARMED;
            WAIT_CMD: state_next = !i_spi_busy ? IDLE :
                                   i_spi_ready ? (i_spi_data_rx[7] ? WR_DATA : RD_DATA) : WAIT_CMD;
            WR_DATA,
            RD_DATA:  state_next = i_spi_busy ? state : IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= IDLE;
            count          <= '0;
            capture        <= 1'b0;
            o_spi_data_tx  <= 8'h00;
            o_reg_addr     <= '0;
            o_reg_wdata    <= 8'h00;
            o_reg_wr       <= 1'b0;
            o_reg_rd       <= 1'b0;
            o_burst_err    <= 1'b0;
            o_frame_active <= 1'b0;
        end else begin
            state          <= state_next;
            o_frame_active <= state_next inside {WAIT_CMD, WR_DATA, RD_DATA};
            o_reg_wr       <= wr_byte;
            o_reg_rd       <= rd_byte || (cmd_byte && !i_spi_data_rx[7]);
            capture        <= o_reg_rd;
            if (wr_byte)
                o_reg_wdata <= i_spi_data_rx;
            if (frame_start) begin
                count       <= '0;
                o_burst_err <= 1'b0;
            end else begin
                if (wr_byte || rd_byte)
                    count <= count + 1'b1;
                if (over_byte)
                    o_burst_err <= 1'b1;
            end
            // writes advance after their strobe, reads advance when the dummy byte arrives
            if (cmd_byte)
                o_reg_addr <= i_spi_data_rx[ADDR_WIDTH-1:0];
            else if (rd_byte || o_reg_wr)
                o_reg_addr <= o_reg_addr + 1'b1;
            o_spi_data_tx <= (state_next != RD_DATA) ? 8'h00 : capture ? i_reg_rdata : o_spi_data_tx;
        end
    end
endmodule

// File: tb/tb_spi_reg_controller.sv
// tb_spi_reg_controller: self-checking bench for spi_reg_controller.
// Drives byte frames, models a register file responder and checks strobes, addresses,
// read-back bytes and the burst error flag against frame-level expectations.
module tb_spi_reg_controller;
    localparam int AW = 7;
    localparam int MB = 16;

    logic          i_clk = 1'b0;
    logic          i_rst, i_spi_ready, i_spi_busy;
    logic [7:0]    i_spi_data_rx, i_reg_rdata;
    logic [7:0]    o_spi_data_tx, o_reg_wdata;
    logic [AW-1:0] o_reg_addr;
    logic          o_reg_wr, o_reg_rd, o_burst_err, o_frame_active;

    spi_reg_controller #(.ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_spi_ready(i_spi_ready), .i_spi_data_rx(i_spi_data_rx),
        .i_spi_busy(i_spi_busy), .o_spi_data_tx(o_spi_data_tx), .o_reg_addr(o_reg_addr),
        .o_reg_wdata(o_reg_wdata), .o_reg_wr(o_reg_wr), .o_reg_rd(o_reg_rd),
        .i_reg_rdata(i_reg_rdata), .o_burst_err(o_burst_err), .o_frame_active(o_frame_active)
    );

    always #5 i_clk = ~i_clk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] mem [0:127];
    logic [7:0] fdata [0:31];
    logic [14:0] wr_q [$];
    logic [6:0]  rd_q [$];
    logic        overlap = 1'b0;

    // register file responder: data valid one cycle after the read strobe, garbage otherwise
    always @(posedge i_clk) i_reg_rdata <= o_reg_rd ? mem[o_reg_addr] : 8'($urandom);

    always @(negedge i_clk) begin
        if (o_reg_wr) wr_q.push_back({o_reg_addr, o_reg_wdata});
        if (o_reg_rd) rd_q.push_back(o_reg_addr);
        if (o_reg_wr && o_reg_rd) overlap <= 1'b1;
    end

    typedef struct {
        logic [7:0] cmd;
        int         n;
        int         exp_cnt;
        logic [6:0] exp_first;
        logic [6:0] exp_last;
        logic       exp_err;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int k = 1);
        repeat (k) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_spi_ready   = 1'b1;
        i_spi_data_rx = b;
        tick();
        i_spi_ready   = 1'b0;
        i_spi_data_rx = 8'($urandom);
    endtask

    task automatic start_frame();
        i_spi_busy = 1'b0;
        tick(3);
        i_spi_busy = 1'b1;
        tick(2);
        check("start_active", 32'(o_frame_active), 1);
        check("start_err_clear", 32'(o_burst_err), 0);
    endtask

    task automatic end_frame();
        tick(3);
        i_spi_busy = 1'b0;
        tick(3);
        check("end_inactive", 32'(o_frame_active), 0);
        check("end_tx_zero", 32'(o_spi_data_tx), 0);
    endtask

    // frame-level model: accepted = min(n, MB); writes at start+i, reads at start+0..accepted
    task automatic run_frame(input logic [7:0] cmd, input int n, input int gap,
                             output int cnt, output logic [6:0] first, output logic [6:0] last,
                             output logic err);
        int         wb, rb, acc, k;
        logic [6:0] a0;
        a0  = cmd[6:0];
        acc = n < MB ? n : MB;
        start_frame();
        wb = wr_q.size();
        rb = rd_q.size();
        send_byte(cmd);
        if (!cmd[7]) begin
            tick(2);
            check("rd_tx", 32'(o_spi_data_tx), 32'(mem[a0]));
        end
        for (int i = 0; i < n; i++) begin
            tick($urandom_range(0, gap));
            send_byte(fdata[i]);
            if (cmd[7]) begin
                check("wr_tx_zero", 32'(o_spi_data_tx), 0);
            end else begin
                tick(2);
                k = (i + 1 < MB) ? i + 1 : MB;
                check("rd_tx", 32'(o_spi_data_tx), 32'(mem[7'(32'(a0) + k)]));
            end
        end
        end_frame();
        err = o_burst_err;
        check("err_flag", 32'(err), 32'(n > MB));
        if (cmd[7]) begin
            cnt = wr_q.size() - wb;
            check("wr_count", cnt, acc);
            check("wr_no_reads", rd_q.size() - rb, 0);
            for (int i = 0; i < acc && i < cnt; i++)
                check("wr_entry", 32'(wr_q[wb+i]), 32'({7'(32'(a0) + i), fdata[i]}));
            first = cnt > 0 ? wr_q[wb][14:8] : 7'h0;
            last  = cnt > 0 ? wr_q[wb+cnt-1][14:8] : 7'h0;
        end else begin
            cnt = rd_q.size() - rb;
            check("rd_count", cnt, acc + 1);
            check("rd_no_writes", wr_q.size() - wb, 0);
            for (int i = 0; i <= acc && i < cnt; i++)
                check("rd_entry", 32'(rd_q[rb+i]), 32'(7'(32'(a0) + i)));
            first = cnt > 0 ? rd_q[rb] : 7'h0;
            last  = cnt > 0 ? rd_q[rb+cnt-1] : 7'h0;
        end
        check("no_overlap", 32'(overlap), 0);
    endtask

    initial begin
        int         cnt, wb;
        logic [6:0] first, last;
        logic       err;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        mem[7'h10] = 8'h3C;
        mem[7'h11] = 8'h4D;
        vecs[0] = '{8'h85, 2,  2,  7'h05, 7'h06, 1'b0};
        vecs[1] = '{8'hFF, 2,  2,  7'h7F, 7'h00, 1'b0};
        vecs[2] = '{8'hA0, 18, 16, 7'h20, 7'h2F, 1'b1};
        vecs[3] = '{8'h90, 16, 16, 7'h10, 7'h1F, 1'b0};
        vecs[4] = '{8'h10, 1,  2,  7'h10, 7'h11, 1'b0};
        vecs[5] = '{8'h7E, 2,  3,  7'h7E, 7'h00, 1'b0};
        vecs[6] = '{8'h00, 17, 17, 7'h00, 7'h10, 1'b1};

        // reset with a frame already in progress: asynchronous clear, frame ignored
        i_rst = 1'b1; i_spi_busy = 1'b1; i_spi_ready = 1'b0; i_spi_data_rx = 8'h00;
        #2;
        check("rst_tx", 32'(o_spi_data_tx), 0);
        check("rst_addr", 32'(o_reg_addr), 0);
        check("rst_wdata", 32'(o_reg_wdata), 0);
        check("rst_strobes", 32'({o_reg_wr, o_reg_rd}), 0);
        check("rst_err_active", 32'({o_burst_err, o_frame_active}), 0);
        tick(2);
        i_rst = 1'b0;
        tick();
        wb = wr_q.size();
        send_byte(8'h85);
        send_byte(8'h12);
        tick(2);
        check("stale_frame_wr", wr_q.size() - wb, 0);
        check("stale_frame_active", 32'(o_frame_active), 0);

        // write burst with back-to-back data bytes
        start_frame();
        send_byte(8'h85);
        send_byte(8'hAA);
        check("wb_wr0", 32'({o_reg_wr, o_reg_addr, o_reg_wdata}), 32'({1'b1, 7'h05, 8'hAA}));
        check("wb_tx0", 32'(o_spi_data_tx), 0);
        send_byte(8'hBB);
        check("wb_wr1", 32'({o_reg_wr, o_reg_addr, o_reg_wdata}), 32'({1'b1, 7'h06, 8'hBB}));
        tick();
        check("wb_wr_end", 32'(o_reg_wr), 0);
        check("wb_tx1", 32'(o_spi_data_tx), 0);
        end_frame();

        // read burst timing: strobe at N+1, tx valid from N+3
        start_frame();
        send_byte(8'h10);
        check("rb_rd0", 32'({o_reg_rd, o_reg_wr, o_reg_addr}), 32'({2'b10, 7'h10}));
        tick();
        check("rb_rd0_off", 32'(o_reg_rd), 0);
        check("rb_tx_n2", 32'(o_spi_data_tx), 0);
        tick();
        check("rb_tx_n3", 32'(o_spi_data_tx), 32'h3C);
        tick();
        send_byte(8'h99);
        check("rb_rd1", 32'({o_reg_rd, o_reg_addr}), 32'({1'b1, 7'h11}));
        check("rb_tx_hold", 32'(o_spi_data_tx), 32'h3C);
        tick(2);
        check("rb_tx1", 32'(o_spi_data_tx), 32'h4D);
        end_frame();

        // last byte coincides with busy falling
        start_frame();
        send_byte(8'h8A);
        tick();
        i_spi_ready = 1'b1; i_spi_data_rx = 8'h77; i_spi_busy = 1'b0;
        tick();
        i_spi_ready = 1'b0;
        check("co_wr", 32'({o_reg_wr, o_reg_addr, o_reg_wdata}), 32'({1'b1, 7'h0A, 8'h77}));
        check("co_idle", 32'(o_frame_active), 0);
        tick();
        check("co_wr_off", 32'(o_reg_wr), 0);

        // reset mid-frame aborts; bytes until busy falls are ignored
        start_frame();
        send_byte(8'h83);
        send_byte(8'h44);
        check("ab_wr", 32'({o_reg_wr, o_reg_addr}), 32'({1'b1, 7'h03}));
        #2 i_rst = 1'b1;
        #1;
        check("ab_async", 32'({o_reg_wr, o_reg_addr, o_reg_wdata, o_frame_active}), 0);
        tick();
        i_rst = 1'b0;
        wb = wr_q.size();
        send_byte(8'h55);
        send_byte(8'h66);
        tick(3);
        check("ab_no_wr", wr_q.size() - wb, 0);
        check("ab_inactive", 32'(o_frame_active), 0);

        // table-driven frames, including wrap and overflow followed by a clearing frame
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 32; i++) fdata[i] = 8'(i * 37 + 5 + v);
            run_frame(vecs[v].cmd, vecs[v].n, 2, cnt, first, last, err);
            check("vec_cnt", cnt, vecs[v].exp_cnt);
            check("vec_first", 32'(first), 32'(vecs[v].exp_first));
            check("vec_last", 32'(last), 32'(vecs[v].exp_last));
            check("vec_err", 32'(err), 32'(vecs[v].exp_err));
        end

        // randomized frames against the frame model
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < 32; i++) fdata[i] = 8'($urandom);
            run_frame(8'($urandom), $urandom_range(0, 19), 3, cnt, first, last, err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
